// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
// Holds the base opcode constants, the ALU operation encoding, the FSM state
// encoding, datapath select encodings, the instruction class used between the
// decoder and the controller, and the branch-resolution helper.
package riscv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // addi x0, x0, 0: the instruction register holds this out of reset
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_SRC_PC4    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JAL    = 2'd2,
        PC_SRC_JALR   = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        A_RS1    = 2'd0,
        A_OLD_PC = 2'd1,
        A_ZERO   = 2'd2
    } alu_a_sel_e;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8,
        CLS_NONE   = 4'd9
    } instr_class_e;

    // Branch compares run through the ALU (SUB / SLT / SLTU); the zero flag
    // then tells equal / not-less-than, so each condition is zero or !zero.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        logic taken;
        case (funct3)
            3'b000:         taken = zero;   // BEQ
            3'b001:         taken = !zero;  // BNE
            3'b100, 3'b110: taken = !zero;  // BLT, BLTU: less-than result is 1
            3'b101, 3'b111: taken = zero;   // BGE, BGEU: less-than result is 0
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction decoder.
// Ports:
//   opcode, funct3, funct7 : fields of the captured instruction
//   cls                    : instruction class
//   alu_op                 : ALU operation used in EXECUTE
//   illegal                : encoding not supported by the core
module control_decoder
    import riscv_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output instr_class_e cls,
    output alu_op_e      alu_op,
    output logic         illegal
);

    // Register/immediate arithmetic; alternate encodings select SUB and SRA.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt_add,
                                         input logic alt_shift);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt_add ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt_shift ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Opcode/funct classification
    always_comb begin
        cls     = CLS_NONE;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OPC_R: begin
                cls    = CLS_R;
                alu_op = arith_op(funct3, funct7[5], funct7[5]);
                // only ADD/SUB and SRL/SRA have a second funct7 encoding
                if (funct7 == 7'b0000000) begin
                    illegal = 1'b0;
                end else if (funct7 == 7'b0100000 &&
                             (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    illegal = 1'b0;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_I: begin
                cls    = CLS_I;
                alu_op = arith_op(funct3, 1'b0, funct7[5]);
                // funct7 is immediate data except for the shift-immediates
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end else begin
                    illegal = 1'b0;
                end
            end
            OPC_LOAD: begin
                cls     = CLS_LOAD;
                illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                cls     = CLS_STORE;
                illegal = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                cls     = CLS_BRANCH;
                alu_op  = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
                illegal = (funct3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                cls = CLS_JAL;
            end
            OPC_JALR: begin
                cls     = CLS_JALR;
                illegal = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                cls = CLS_LUI;
            end
            OPC_AUIPC: begin
                cls = CLS_AUIPC;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I datapath: FETCH, DECODE, EXECUTE,
// MEM, WRITEBACK, plus a sticky FAULT state for illegal instructions and
// memory timeouts.
// Ports:
//   clk, reset (sync, active low)
//   instr, imem_ready, dmem_ready, zero          : memory / ALU status inputs
//   imem_req, dmem_req, dmem_we                  : memory requests
//   ir_write, pc_write, pc_src, reg_write        : datapath enables
//   alu_src, alu_a_sel, alu_op, wb_sel           : datapath selects
//   fault, state                                 : status / debug
// MAX_WAIT: cycles a request may go unanswered before FAULT (0 = no limit).
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        alu_src,
    output logic [1:0]  alu_a_sel,
    output logic [3:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        fault,
    output logic [2:0]  state
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_e       state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    logic [7:0]   wait_q, wait_d;

    instr_class_e cls_s;
    alu_op_e      dec_alu_op_s;
    logic         illegal_s;
    logic [4:0]   rd_s;
    logic         wait_expired_s;
    logic [7:0]   wait_inc_s;
    logic         unused_operand_bits_s;

    logic         imem_req_s, dmem_req_s, dmem_we_s, ir_write_s, pc_write_s;
    pc_src_e      pc_src_s;
    logic         reg_write_s, alu_src_s, fault_s;
    alu_a_sel_e   alu_a_sel_s;
    alu_op_e      alu_op_s;
    wb_sel_e      wb_sel_s;

    control_decoder u_decoder (
        .opcode  (ir_q[6:0]),
        .funct3  (ir_q[14:12]),
        .funct7  (ir_q[31:25]),
        .cls     (cls_s),
        .alu_op  (dec_alu_op_s),
        .illegal (illegal_s)
    );

    assign rd_s = ir_q[11:7];
    // register-source fields belong to the datapath, not to control
    assign unused_operand_bits_s = ^ir_q[24:15];

    // Timeout fires on the cycle that would bring the count up to the limit;
    // a ready in that same cycle is checked first and wins.
    assign wait_expired_s = (MAX_WAIT_C != 8'd0) && ((wait_q + 8'd1) == MAX_WAIT_C);
    assign wait_inc_s     = (wait_q == 8'hFF) ? wait_q : (wait_q + 8'd1);

    // Next-state and unmasked datapath control
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        wait_d      = 8'd0;
        imem_req_s  = 1'b0;
        dmem_req_s  = 1'b0;
        dmem_we_s   = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        pc_src_s    = PC_SRC_PC4;
        reg_write_s = 1'b0;
        wb_sel_s    = WB_ALU;
        fault_s     = 1'b0;
        alu_op_s    = ALU_ADD;
        alu_src_s   = 1'b0;
        alu_a_sel_s = A_RS1;

        // ALU controls stay stable from EXECUTE through WRITEBACK
        if (state_q == ST_EXECUTE || state_q == ST_MEM || state_q == ST_WRITEBACK) begin
            alu_op_s  = dec_alu_op_s;
            alu_src_s = (cls_s != CLS_R) && (cls_s != CLS_BRANCH);
            case (cls_s)
                CLS_LUI:            alu_a_sel_s = A_ZERO;
                CLS_AUIPC, CLS_JAL: alu_a_sel_s = A_OLD_PC;
                default:            alu_a_sel_s = A_RS1;
            endcase
        end else begin
            alu_op_s    = ALU_ADD;
            alu_src_s   = 1'b0;
            alu_a_sel_s = A_RS1;
        end

        case (state_q)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    pc_src_s   = PC_SRC_PC4;
                    ir_d       = instr;
                    state_d    = ST_DECODE;
                end else if (wait_expired_s) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            ST_DECODE: begin
                if (illegal_s) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (cls_s)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH: begin
                        if (branch_taken(ir_q[14:12], zero)) begin
                            pc_write_s = 1'b1;
                            pc_src_s   = PC_SRC_BRANCH;
                        end else begin
                            pc_write_s = 1'b0;
                        end
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (cls_s == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_s == CLS_LOAD) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (wait_expired_s) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            ST_WRITEBACK: begin
                reg_write_s = (rd_s != 5'd0);
                case (cls_s)
                    CLS_LOAD: wb_sel_s = WB_MEM;
                    CLS_JAL: begin
                        wb_sel_s   = WB_PC4;
                        pc_write_s = 1'b1;
                        pc_src_s   = PC_SRC_JAL;
                    end
                    CLS_JALR: begin
                        wb_sel_s   = WB_PC4;
                        pc_write_s = 1'b1;
                        pc_src_s   = PC_SRC_JALR;
                    end
                    default: wb_sel_s = WB_ALU;
                endcase
                state_d = ST_FETCH;
            end
            ST_FAULT: begin
                fault_s = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Port drive: everything held low while reset is asserted
    always_comb begin
        if (reset) begin
            imem_req  = imem_req_s;
            dmem_req  = dmem_req_s;
            dmem_we   = dmem_we_s;
            ir_write  = ir_write_s;
            pc_write  = pc_write_s;
            pc_src    = pc_src_s;
            reg_write = reg_write_s;
            alu_src   = alu_src_s;
            alu_a_sel = alu_a_sel_s;
            alu_op    = alu_op_s;
            wb_sel    = wb_sel_s;
            fault     = fault_s;
            state     = state_q;
        end else begin
            imem_req  = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'd0;
            reg_write = 1'b0;
            alu_src   = 1'b0;
            alu_a_sel = 2'd0;
            alu_op    = 4'd0;
            wb_sel    = 2'd0;
            fault     = 1'b0;
            state     = ST_FETCH;
        end
    end

    // State, instruction and wait-counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= NOP_INSTR;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: a per-cycle expectation queue is built from the
// instruction-level timing rules, then replayed against the controller.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset, imem_ready, dmem_ready, zero;
    logic [31:0] instr;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write;
    logic        alu_src, fault;
    logic [1:0]  pc_src, alu_a_sel, wb_sel;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    always #5 clk = ~clk;

    multicycle_controller #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .zero       (zero),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_a_sel  (alu_a_sel),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .fault      (fault),
        .state      (state)
    );

    localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23;
    localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67;
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;

    typedef struct packed {
        logic [3:0]  tag;
        logic        rst_n;
        logic [31:0] instr;
        logic        iready, dready, zero;
        logic        chk_alu;
        logic [2:0]  st;
        logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
        logic [1:0]  pc_src;
        logic        reg_write, alu_src;
        logic [1:0]  asel;
        logic [3:0]  aop;
        logic [1:0]  wb;
        logic        fault;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    logic cur_valid = 1'b0;
    int   tests = 0, fails = 0, cyc = 0;
    int   len_add, len_beq, len_lw, len_sw;
    int   tag1_cycles = 0, tag1_dreq = 0, tag2_fetch = 0;

    function automatic rec_t blank(input logic [3:0] tag);
        rec_t r;
        r       = '0;
        r.tag   = tag;
        r.rst_n = 1'b1;
        r.instr = 32'h0000_007F;   // garbage on the bus whenever not accepted
        return r;
    endfunction

    function automatic logic legal_op(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    // ALU op expected in EXECUTE (0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND)
    function automatic logic [3:0] model_alu(input logic [31:0] ins);
        logic [3:0] tab [0:7];
        logic [2:0] f3;
        logic [6:0] op;
        tab[0] = 4'd0; tab[1] = 4'd2; tab[2] = 4'd3; tab[3] = 4'd4;
        tab[4] = 4'd5; tab[5] = 4'd6; tab[6] = 4'd8; tab[7] = 4'd9;
        f3 = ins[14:12];
        op = ins[6:0];
        if (op == OP_BR) return !f3[2] ? 4'd1 : (f3[1] ? 4'd4 : 4'd3);
        if (op == OP_R || op == OP_I) begin
            if (op == OP_R && f3 == 3'd0 && ins[30]) return 4'd1;
            if (f3 == 3'd5 && ins[30]) return 4'd7;
            return tab[f3];
        end
        return 4'd0;
    endfunction

    // Push the expected cycles of one instruction. iw/dw: wait cycles before
    // ready; abort_mem >= 0 stops after that many unanswered MEM cycles.
    task automatic push_instr(input logic [31:0] ins, input int iw, input int dw,
                              input logic z, input int abort_mem, input logic [3:0] tag);
        rec_t r;
        logic [6:0] op;
        logic [2:0] f3;
        logic taken;
        op = ins[6:0];
        f3 = ins[14:12];
        for (int k = 0; k <= iw; k++) begin
            r = blank(tag);
            r.imem_req = 1'b1;
            if (k == iw) begin
                r.iready = 1'b1; r.instr = ins; r.ir_write = 1'b1; r.pc_write = 1'b1;
            end
            q.push_back(r);
        end
        r = blank(tag); r.st = 3'd1; q.push_back(r);
        if (!legal_op(op)) return;
        r = blank(tag);
        r.st = 3'd2; r.chk_alu = 1'b1; r.zero = z;
        r.aop = model_alu(ins);
        r.alu_src = !(op == OP_R || op == OP_BR);
        r.asel = (op == OP_LUI) ? 2'd2 : ((op == OP_AUIPC || op == OP_JAL) ? 2'd1 : 2'd0);
        if (op == OP_BR) begin
            taken = (f3[0] == 1'b0) ? (f3[2] ? !z : z) : (f3[2] ? z : !z);
            r.pc_write = taken;
            r.pc_src   = taken ? 2'd1 : 2'd0;
            q.push_back(r);
            return;
        end
        q.push_back(r);
        if (op == OP_LD || op == OP_ST) begin
            if (abort_mem >= 0) begin
                for (int k = 0; k < abort_mem; k++) begin
                    r = blank(tag); r.st = 3'd3; r.dmem_req = 1'b1; r.dmem_we = (op == OP_ST);
                    q.push_back(r);
                end
                return;
            end
            for (int k = 0; k <= dw; k++) begin
                r = blank(tag); r.st = 3'd3; r.dmem_req = 1'b1; r.dmem_we = (op == OP_ST);
                r.dready = (k == dw);
                q.push_back(r);
            end
            if (op == OP_ST) return;
        end
        r = blank(tag);
        r.st = 3'd4;
        r.reg_write = (ins[11:7] != 5'd0);
        r.wb = (op == OP_LD) ? 2'd1 : ((op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0);
        if (op == OP_JAL)  begin r.pc_write = 1'b1; r.pc_src = 2'd2; end
        if (op == OP_JALR) begin r.pc_write = 1'b1; r.pc_src = 2'd3; end
        q.push_back(r);
    endtask

    task automatic push_reset(input int n);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r = blank(4'd0); r.rst_n = 1'b0; r.iready = 1'b1; r.dready = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic push_fault(input int n);
        rec_t r;
        for (int k = 0; k < n; k++) begin
            r = blank(4'd0); r.st = 3'd5; r.fault = 1'b1; r.iready = 1'b1; r.dready = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Compare process: DUT outputs against the expectation for this cycle
    always @(negedge clk) begin
        if (cur_valid) begin
            cyc++;
            chk("state", int'(state), int'(cur.st));
            chk("imem_req", int'(imem_req), int'(cur.imem_req));
            chk("dmem_req", int'(dmem_req), int'(cur.dmem_req));
            chk("dmem_we", int'(dmem_we), int'(cur.dmem_we));
            chk("ir_write", int'(ir_write), int'(cur.ir_write));
            chk("pc_write", int'(pc_write), int'(cur.pc_write));
            chk("pc_src", int'(pc_src), int'(cur.pc_src));
            chk("reg_write", int'(reg_write), int'(cur.reg_write));
            chk("wb_sel", int'(wb_sel), int'(cur.wb));
            chk("fault", int'(fault), int'(cur.fault));
            if (cur.chk_alu) begin
                chk("alu_op", int'(alu_op), int'(cur.aop));
                chk("alu_src", int'(alu_src), int'(cur.alu_src));
                chk("alu_a_sel", int'(alu_a_sel), int'(cur.asel));
            end
            if (cur.tag == 4'd1) begin
                tag1_cycles++;
                if (dmem_req) tag1_dreq++;
            end
            if (cur.tag == 4'd2 && state == 3'd0) tag2_fetch++;
            if (cur.tag == 4'd15) begin
                chk("cpi_add", len_add, 4);
                chk("cpi_beq", len_beq, 3);
                chk("cpi_lw_wait3", len_lw, 8);
                chk("cpi_sw", len_sw, 4);
                chk("lw_cycles_observed", tag1_cycles, 8);
                chk("lw_dmem_req_cycles", tag1_dreq, 4);
                chk("timeout_fetch_cycles", tag2_fetch, 4);
            end
        end
    end

    initial begin
        int n0;
        rec_t r;
        reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        instr = 32'h0000_007F;

        push_reset(2);
        n0 = q.size(); push_instr(32'h002081B3, 0, 0, 1'b0, -1, 4'd0); len_add = q.size() - n0;
        n0 = q.size(); push_instr(32'h00208463, 0, 0, 1'b1, -1, 4'd0); len_beq = q.size() - n0;
        push_instr(32'h00209463, 0, 0, 1'b1, -1, 4'd0);                       // bne, zero=1
        n0 = q.size(); push_instr(32'h0000A183, 0, 3, 1'b0, -1, 4'd1); len_lw = q.size() - n0;
        n0 = q.size(); push_instr(32'h0020A023, 0, 0, 1'b0, -1, 4'd0); len_sw = q.size() - n0;
        push_instr(32'h00000013, 0, 0, 1'b0, -1, 4'd0);                       // addi x0
        push_instr(32'h010000EF, 0, 0, 1'b0, -1, 4'd0);                       // jal x1
        push_instr(32'h00008067, 0, 0, 1'b0, -1, 4'd0);                       // jalr x0
        push_instr(32'h123452B7, 0, 0, 1'b0, -1, 4'd0);                       // lui
        push_instr(32'h00001317, 0, 0, 1'b0, -1, 4'd0);                       // auipc
        push_instr(32'h0020C463, 0, 0, 1'b0, -1, 4'd0);                       // blt taken
        push_instr(32'h0020F463, 0, 0, 1'b0, -1, 4'd0);                       // bgeu not taken
        push_instr(32'h402081B3, 0, 0, 1'b0, -1, 4'd0);                       // sub
        push_instr(32'h002081B3, 3, 0, 1'b0, -1, 4'd0);                       // ready on 4th fetch cycle
        // reset in the middle of a store's MEM phase, then a late ready
        push_instr(32'h0020A023, 0, 0, 1'b0, 2, 4'd0);
        push_reset(1);
        r = blank(4'd0); r.imem_req = 1'b1; r.dready = 1'b1; q.push_back(r);
        push_instr(32'h002081B3, 0, 0, 1'b0, -1, 4'd0);
        // illegal opcode
        push_instr(32'h0000007F, 0, 0, 1'b0, -1, 4'd0);
        push_fault(4);
        push_reset(1);
        // fetch timeout
        for (int k = 0; k < 4; k++) begin
            r = blank(4'd2); r.imem_req = 1'b1; q.push_back(r);
        end
        push_fault(3);
        push_reset(1);
        push_instr(32'h002081B3, 0, 0, 1'b0, -1, 4'd0);
        r = blank(4'd15); r.imem_req = 1'b1; q.push_back(r);

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            reset      = q[i].rst_n;
            imem_ready = q[i].iready;
            dmem_ready = q[i].dready;
            zero       = q[i].zero;
            instr      = q[i].instr;
            cur        = q[i];
            cur_valid  = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM that sequences the RV32I core datapath (program counter, instruction memory, register file, ALU, operand mux) across fetch, decode, execute, memory and writeback. It captures each fetched instruction, decodes its class and drives every datapath enable and select. Instruction and data memory accesses use a req/ready handshake with a bounded wait. Sits in `top` between the memories and the datapath and replaces the hard-wired `alu_src` tie-off.

## Interface
- `MAX_WAIT`, 255: cycles a req may stay unanswered before FAULT; 0 disables the timeout.
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-low reset.
- `instr`  in  32  instruction memory read data; sampled only on FETCH accept.
- `imem_ready`  in  1  instruction fetch complete.
- `dmem_ready`  in  1  data access complete.
- `zero`  in  1  ALU zero flag.
- `imem_req`  out  1  fetch request.
- `dmem_req`  out  1  data request.
- `dmem_we`  out  1  data write (store).
- `ir_write`  out  1  datapath latches instruction and old PC.
- `pc_write`  out  1  PC register update.
- `pc_src`  out  2  PC4 / BRANCH / JAL / JALR target.
- `reg_write`  out  1  register file write enable.
- `alu_src`  out  1  0 = rs2, 1 = immediate.
- `alu_a_sel`  out  2  RS1 / OLD_PC / ZERO.
- `alu_op`  out  4  ALU operation (`alu_op_e`).
- `wb_sel`  out  2  ALU / MEM / PC4.
- `fault`  out  1  sticky: illegal opcode or timeout.
- `state`  out  3  current state, for debug.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FAULT.
- FETCH:
  - `imem_req`=1.
  - On `imem_ready`: `ir_write`=1, `pc_write`=1 with `pc_src`=PC4; capture `instr` internally; go to DECODE.
- DECODE: one cycle; classify opcode; unknown opcode -> FAULT.
- EXECUTE: drive `alu_op`, `alu_src`, `alu_a_sel` per class.
  - Paths: R and I-ALU -> WRITEBACK; LOAD and STORE (address add) -> MEM; LUI, AUIPC, JAL, JALR -> WRITEBACK.
  - BRANCH: `alu_op`=SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - Taken when: BEQ `zero`; BNE `!zero`; BLT/BLTU `!zero`; BGE/BGEU `zero`.
  - If taken: `pc_write`=1, `pc_src`=BRANCH. Then -> FETCH.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for STORE only.
  - On `dmem_ready`: LOAD -> WRITEBACK; STORE -> FETCH.
- WRITEBACK:
  - `reg_write`=1 unless rd==0.
  - `wb_sel`: MEM for LOAD, PC4 for JAL/JALR, ALU otherwise.
  - JAL/JALR also assert `pc_write` with `pc_src`=JAL/JALR.
  - Then -> FETCH.
- FAULT: all enables and reqs 0, `fault`=1; exits only on reset.
- Wait counter (8 bits minimum; saturates at `MAX_WAIT`):
  - Increments each FETCH/MEM cycle without ready; clears on state change.
  - Reaching `MAX_WAIT` -> FAULT.
  - Ready in the same cycle as the limit: ready wins.
- Handshake:
  - Req held high, with `dmem_we` stable, until ready.
  - Ready while the matching req is low is ignored.

## Timing
- Outputs decode combinationally from the state register and captured instruction fields. No combinational path from `instr` to outputs.
- While `reset`=0 at a clock edge: state <- FETCH, captured instruction <- NOP (addi x0), wait counter <- 0, `fault` <- 0.
  - During reset, all outputs except `state` are forced 0; `state` reads FETCH.
- First `imem_req` is in the first cycle after reset deasserts.
- Cycles per instruction with zero-wait memories:
  - BRANCH: 3.
  - R, I-ALU, LUI, AUIPC, JAL, JALR, STORE: 4.
  - LOAD: 5.
  - Each memory wait cycle adds 1.
- Reset mid-MEM or mid-FETCH: req drops the cycle after the reset edge; a late ready is ignored; no `reg_write` or `pc_write` occurs.

## Structure
- `riscv_pkg` holds:
  - opcode constants (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111);
  - `alu_op_e`, `state_e`, `pc_src_e`, `wb_sel_e`, `alu_a_sel_e`.
- Sub-module `control_decoder`: combinational; maps opcode/funct3/funct7 to instruction class, `alu_op` and an illegal flag. The FSM stays in `multicycle_controller`.

## Test plan
- `add` (0x002081B3), zero-wait memories -> FETCH, DECODE, EXECUTE, WRITEBACK in 4 cycles; `reg_write`=1, `wb_sel`=ALU, `alu_src`=0.
- `beq` with `zero`=1 -> `pc_write`=1, `pc_src`=BRANCH in EXECUTE; back in FETCH on cycle 4. `bne` with `zero`=1 -> no `pc_write` in EXECUTE.
- `lw` with `dmem_ready` delayed 3 cycles -> `dmem_req` high 4 cycles, `dmem_we`=0; WRITEBACK with `wb_sel`=MEM; 8 cycles total.
- Opcode 0x7F -> FAULT after DECODE; `fault`=1 and all reqs 0 until reset.
- `MAX_WAIT`=4, `imem_ready` never asserted -> FAULT after 4 waiting cycles. Repeat with ready on the 4th cycle -> DECODE, no fault.
- `reset`=0 during MEM of `sw` -> next cycle `dmem_req`=0, state FETCH, no `reg_write` or `pc_write`.
